// File: rtl/tx_hex_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_hex_arbiter
// Purpose  : Shares one AVR UART transmit channel between NREQ 32-bit
//            reporting sources. Requesters are granted round-robin. The
//            granted value is latched, and then a newline plus DIGITS
//            lowercase ASCII hex characters are streamed to avr_interface.
//            The tx_busy / tx_block flow control is honoured throughout.
//
// Parameters:
//   NREQ        number of requesters (1..8)
//   DIGITS      hex digits per report (1..8)
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   req_valid    in   [NREQ]      requester i has a value to print
//   req_data     in   [32*NREQ]   value i at bits [32*i+31:32*i]
//   req_ack      out  [NREQ]      one-cycle grant pulse (value captured)
//   tx_data      out  [8]         byte to avr_interface
//   new_tx_data  out  1           one-cycle strobe, tx_data valid
//   tx_busy      in   1           UART transmitter busy
//   tx_block     in   1           AVR receive buffer full
//   busy         out  1           report in progress
//
// Build option:
//   TX_ARB_MSB_FIRST_EN  when defined, digits are sent most-significant
//                        nibble first. Otherwise the least-significant
//                        nibble is sent first.
//
// Revision : 1.0  initial release
// ============================================================================
module tx_hex_arbiter #(
    parameter int NREQ   = 3,
    parameter int DIGITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ack,
    output logic [7:0]           tx_data,
    output logic                 new_tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_block,
    output logic                 busy
);

    localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] c_ptr_rst = PW'(NREQ - 1);
    localparam logic [3:0]  c_digits  = 4'(DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [3:0]      r_idx;
    logic [31:0]     r_value;

    state_t          w_state_nxt;
    logic [PW-1:0]   w_ptr_nxt;
    logic [3:0]      w_idx_nxt;
    logic [31:0]     w_value_nxt;
    logic [NREQ-1:0] w_ack_nxt;
    logic [7:0]      w_tx_data_nxt;
    logic            w_strobe_nxt;

    logic            w_any;
    logic [PW-1:0]   w_gnt_idx;
    logic [NREQ-1:0] w_gnt_onehot;
    logic [31:0]     w_gnt_data;

    logic [3:0]      w_nib_pos;
    logic [3:0]      w_nib;
    logic [7:0]      w_char;

    // ------------------------------------------------------------------
    // Round-robin selection. The first pass covers the wrapped candidates
    // (index <= pointer). The second pass covers the candidates after the
    // pointer, and it overrides the first pass. Each pass scans downward,
    // so the lowest index of each group wins. As a result, the first
    // asserted index after the pointer is chosen, wrapping around.
    // ------------------------------------------------------------------
    always_comb begin
        w_any        = 1'b0;
        w_gnt_idx    = '0;
        w_gnt_data   = '0;
        w_gnt_onehot = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i <= int'(r_ptr))) begin
                w_any      = 1'b1;
                w_gnt_idx  = PW'(i);
                w_gnt_data = req_data[32*i +: 32];
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i > int'(r_ptr))) begin
                w_any      = 1'b1;
                w_gnt_idx  = PW'(i);
                w_gnt_data = req_data[32*i +: 32];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            w_gnt_onehot[i] = w_any && (PW'(i) == w_gnt_idx);
        end
    end

    // ------------------------------------------------------------------
    // Character generation. Index 0 is the newline. Indices 1..DIGITS
    // select a nibble of the captured value.
    // ------------------------------------------------------------------
    always_comb begin
`ifdef TX_ARB_MSB_FIRST_EN
        w_nib_pos = c_digits - r_idx;
`else
        w_nib_pos = r_idx - 4'd1;
`endif
        w_nib = 4'(r_value >> {w_nib_pos, 2'b00});
        if (r_idx == 4'd0) begin
            w_char = 8'h0A;
        end else if (w_nib < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nib};
        end else begin
            // 0x61 - 10 = 0x57, so that nibble 10 maps to 'a'.
            w_char = 8'h57 + {4'h0, w_nib};
        end
    end

    // ------------------------------------------------------------------
    // State register. All outputs except busy are registered, so an
    // asynchronous reset clears them at once without a strobe glitch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= c_ptr_rst;
            r_idx       <= 4'd0;
            r_value     <= 32'd0;
            req_ack     <= '0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_idx       <= w_idx_nxt;
            r_value     <= w_value_nxt;
            req_ack     <= w_ack_nxt;
            tx_data     <= w_tx_data_nxt;
            new_tx_data <= w_strobe_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        w_value_nxt   = r_value;
        w_ack_nxt     = '0;
        w_tx_data_nxt = tx_data;
        w_strobe_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_ack_nxt   = w_gnt_onehot;
                    w_value_nxt = w_gnt_data;
                    w_ptr_nxt   = w_gnt_idx;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (!tx_busy && !tx_block) begin
                    w_tx_data_nxt = w_char;
                    w_strobe_nxt  = 1'b1;
                    w_state_nxt   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Avoids sampling tx_busy before avr_interface has raised it.
                if (r_idx == c_digits) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = ST_EMIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_hex_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_hex_arbiter
// Purpose  : Self-checking bench for tx_hex_arbiter. A cycle-level
//            scoreboard predicts grants, strobes, bytes and busy from the
//            arbitration and formatting rules. Scenario tasks add
//            end-to-end checks on top of the scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_tx_hex_arbiter;

    localparam int NREQ   = 3;
    localparam int DIGITS = 8;
`ifdef TX_ARB_MSB_FIRST_EN
    localparam int LSD_POS = DIGITS;
`else
    localparam int LSD_POS = 1;
`endif

    typedef logic [7:0] bq_t[$];

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [32*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     req_ack;
    logic [7:0]          tx_data;
    logic                new_tx_data;
    logic                tx_busy;
    logic                tx_block;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;

    tx_hex_arbiter #(.NREQ(NREQ), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .tx_block    (tx_block),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected byte stream of one report, built from the printed hex string.
    function automatic bq_t exp_report(input logic [31:0] v);
        bq_t   q;
        string s;
        s = $sformatf("%08x", v);
        q.push_back(8'h0A);
`ifdef TX_ARB_MSB_FIRST_EN
        for (int k = DIGITS - 1; k >= 0; k--) q.push_back(s[7-k]);
`else
        for (int k = 0; k < DIGITS; k++) q.push_back(s[7-k]);
`endif
        return q;
    endfunction

    // ---------------- UART transmitter model ----------------
    int busy_len  = 0;
    bit rand_busy = 0;
    int busy_cnt  = 0;
    always @(negedge clk) begin
        if (rst) busy_cnt = 0;
        else if (new_tx_data) busy_cnt = rand_busy ? int'($urandom_range(0, 4)) : busy_len;
        tx_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
    end

    // ---------------- scoreboard ----------------
    int         m_ptr = NREQ - 1;
    bit         m_rep = 0;
    bit         m_last = 0;
    bit         m_prev = 0;
    logic [7:0] m_byte = 8'h00;
    bq_t        exp_q;
    bq_t        rx_bytes;
    int         gnt_log[$];
    int         ack_cnt[NREQ];
    int         strobe_cnt = 0;
    int         cyc_cnt = 0;

    always begin
        logic [NREQ-1:0] e_ack;
        bit              e_stb;
        bit              found;
        int              j;
        @(posedge clk);
        #2;
        cyc_cnt++;
        if (rst) begin
            m_ptr  = NREQ - 1;
            m_rep  = 0;
            m_last = 0;
            m_prev = 0;
            m_byte = 8'h00;
            exp_q.delete();
        end else begin
            e_ack = '0;
            e_stb = 0;
            found = 0;
            if (m_last) begin
                m_last = 0;
            end else if (!m_rep) begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (m_ptr + k) % NREQ;
                    if (!found && req_valid[j]) begin
                        found    = 1;
                        e_ack[j] = 1'b1;
                        m_ptr    = j;
                        m_rep    = 1;
                        exp_q    = exp_report(req_data[32*j +: 32]);
                        gnt_log.push_back(j);
                    end
                end
            end else begin
                e_stb = !m_prev && !tx_busy && !tx_block;
            end

            n_checks++;
            if (req_ack !== e_ack) begin
                n_errors++;
                $display("FAIL ack @%0t: got %b expected %b", $time, req_ack, e_ack);
            end
            n_checks++;
            if (new_tx_data !== e_stb) begin
                n_errors++;
                $display("FAIL strobe @%0t: got %b expected %b", $time, new_tx_data, e_stb);
            end
            if (new_tx_data === 1'b1) begin
                strobe_cnt++;
                rx_bytes.push_back(tx_data);
                if (exp_q.size() > 0) begin
                    m_byte = exp_q.pop_front();
                    n_checks++;
                    if (tx_data !== m_byte) begin
                        n_errors++;
                        $display("FAIL byte @%0t: got %h expected %h", $time, tx_data, m_byte);
                    end
                    if (exp_q.size() == 0) begin
                        m_rep  = 0;
                        m_last = 1;
                    end
                end else begin
                    m_byte = tx_data;
                end
            end else begin
                n_checks++;
                if (tx_data !== m_byte) begin
                    n_errors++;
                    $display("FAIL hold @%0t: got %h expected %h", $time, tx_data, m_byte);
                end
            end
            for (int i = 0; i < NREQ; i++) if (req_ack[i] === 1'b1) ack_cnt[i]++;
            m_prev = (new_tx_data === 1'b1);
            n_checks++;
            if (busy !== (m_rep || m_last)) begin
                n_errors++;
                $display("FAIL busy @%0t: got %b expected %b", $time, busy, (m_rep || m_last));
            end
        end
    end

    // ---------------- helpers (waiting only) ----------------
    task automatic wait_ack(input int idx, input int bound, output int lat);
        lat = -1;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (req_ack[idx] === 1'b1) begin
                lat = c + 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        int quiet = 0;
        ok = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (busy === 1'b0 && req_valid == '0) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        tx_block = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ack !== '0) begin n_errors++; $display("FAIL rst_ack: got %b expected 0", req_ack); end
        n_checks++;
        if (tx_data !== 8'h00) begin n_errors++; $display("FAIL rst_txdata: got %h expected 00", tx_data); end
        n_checks++;
        if (new_tx_data !== 1'b0) begin n_errors++; $display("FAIL rst_strobe: got %b expected 0", new_tx_data); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || req_ack !== '0) begin
            n_errors++;
            $display("FAIL post_rst_idle: got busy=%b ack=%b expected 0/0", busy, req_ack);
        end
    endtask

    task automatic test_fairness;
        bit ok;
        gnt_log.delete();
        rx_bytes.delete();
        @(negedge clk);
        req_data  = {32'h2, 32'h1, 32'h0};
        req_valid = 3'b111;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (gnt_log.size() >= 4) begin
                req_valid = '0;
                break;
            end
        end
        req_valid = '0;
        wait_idle(200, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL fair_timeout: got busy expected idle"); end
        n_checks++;
        if (gnt_log.size() != 4) begin
            n_errors++;
            $display("FAIL fair_count: got %0d grants expected 4", gnt_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (gnt_log[k] != k % 3) begin
                    n_errors++;
                    $display("FAIL fair_order[%0d]: got %0d expected %0d", k, gnt_log[k], k % 3);
                end
            end
        end
        n_checks++;
        if (rx_bytes.size() != 36) begin
            n_errors++;
            $display("FAIL fair_bytes: got %0d bytes expected 36", rx_bytes.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (rx_bytes[9*k] !== 8'h0A || rx_bytes[9*k+LSD_POS] !== 8'(8'h30 + k % 3)) begin
                    n_errors++;
                    $display("FAIL fair_report[%0d]: got %h/%h expected 0a/%h", k,
                             rx_bytes[9*k], rx_bytes[9*k+LSD_POS], 8'(8'h30 + k % 3));
                end
            end
        end
    endtask

    task automatic test_single;
        logic [7:0] exp_single [9];
        int lat;
        bit ok;
`ifdef TX_ARB_MSB_FIRST_EN
        exp_single = '{8'h0A, 8'h30, 8'h31, 8'h32, 8'h33, 8'h61, 8'h62, 8'h63, 8'h64};
`else
        exp_single = '{8'h0A, 8'h64, 8'h63, 8'h62, 8'h61, 8'h33, 8'h32, 8'h31, 8'h30};
`endif
        rx_bytes.delete();
        @(negedge clk);
        req_data[31:0] = 32'h0123ABCD;
        req_valid[0]   = 1'b1;
        wait_ack(0, 50, lat);
        req_valid[0] = 1'b0;
        n_checks++;
        if (lat != 1) begin n_errors++; $display("FAIL single_ack_latency: got %0d expected 1", lat); end
        wait_idle(200, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL single_timeout: got busy expected idle"); end
        n_checks++;
        if (rx_bytes.size() != 9) begin
            n_errors++;
            $display("FAIL single_len: got %0d expected 9", rx_bytes.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                n_checks++;
                if (rx_bytes[k] !== exp_single[k]) begin
                    n_errors++;
                    $display("FAIL single_byte[%0d]: got %h expected %h", k, rx_bytes[k], exp_single[k]);
                end
            end
        end
    endtask

    task automatic test_flow_block;
        int lat, s0;
        bit ok;
        @(negedge clk);
        tx_block = 1'b1;
        req_data[95:64] = $urandom;
        req_valid[2] = 1'b1;
        wait_ack(2, 50, lat);
        req_valid[2] = 1'b0;
        s0 = strobe_cnt;
        repeat (100) @(negedge clk);
        n_checks++;
        if (strobe_cnt != s0) begin
            n_errors++;
            $display("FAIL block_stall: got %0d strobes expected 0", strobe_cnt - s0);
        end
        tx_block = 1'b0;
        wait_idle(200, ok);
        n_checks++;
        if (!ok || strobe_cnt - s0 != 9) begin
            n_errors++;
            $display("FAIL block_release: got %0d strobes expected 9", strobe_cnt - s0);
        end
    endtask

    task automatic test_flow_busy;
        int lat, s0, c0;
        bit ok;
        busy_len = 40;
        @(negedge clk);
        req_data[63:32] = $urandom;
        req_valid[1] = 1'b1;
        wait_ack(1, 50, lat);
        req_valid[1] = 1'b0;
        s0 = strobe_cnt;
        c0 = cyc_cnt;
        wait_idle(1000, ok);
        n_checks++;
        if (!ok || strobe_cnt - s0 != 9) begin
            n_errors++;
            $display("FAIL busy_count: got %0d strobes expected 9", strobe_cnt - s0);
        end
        n_checks++;
        if (cyc_cnt - c0 < 8 * 41) begin
            n_errors++;
            $display("FAIL busy_pacing: got %0d cycles expected >= %0d", cyc_cnt - c0, 8 * 41);
        end
        busy_len = 0;
        repeat (45) @(negedge clk);
    endtask

    task automatic test_withdraw;
        int lat;
        bit ok;
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
        rx_bytes.delete();
        @(negedge clk);
        req_data[31:0] = $urandom;
        req_valid[0] = 1'b1;
        wait_ack(0, 50, lat);
        req_valid[0] = 1'b0;
        @(negedge clk);
        req_data[63:32] = $urandom;
        req_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        req_valid[1] = 1'b0;
        wait_idle(200, ok);
        n_checks++;
        if (ack_cnt[1] != 0) begin n_errors++; $display("FAIL withdraw_ack1: got %0d expected 0", ack_cnt[1]); end
        n_checks++;
        if (ack_cnt[0] != 1) begin n_errors++; $display("FAIL withdraw_ack0: got %0d expected 1", ack_cnt[0]); end
        n_checks++;
        if (!ok || rx_bytes.size() != 9) begin
            n_errors++;
            $display("FAIL withdraw_len: got %0d expected 9", rx_bytes.size());
        end
    endtask

    task automatic test_reset_mid;
        int lat, s0;
        bit ok;
        @(negedge clk);
        s0 = strobe_cnt;
        req_data[63:32] = $urandom;
        req_valid[1] = 1'b1;
        wait_ack(1, 50, lat);
        req_valid[1] = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #3;
            if (strobe_cnt - s0 >= 3) break;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (new_tx_data !== 1'b0 || tx_data !== 8'h00 || req_ack !== '0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_rst_outputs: got stb=%b data=%h ack=%b busy=%b expected all 0",
                     new_tx_data, tx_data, req_ack, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rx_bytes.delete();
        s0 = strobe_cnt;
        @(negedge clk);
        req_data[95:64] = $urandom;
        req_valid[2] = 1'b1;
        wait_ack(2, 50, lat);
        req_valid[2] = 1'b0;
        n_checks++;
        if (lat != 1) begin n_errors++; $display("FAIL mid_rst_ack: got %0d expected 1", lat); end
        wait_idle(200, ok);
        n_checks++;
        if (!ok || rx_bytes.size() != 9 || rx_bytes[0] !== 8'h0A) begin
            n_errors++;
            $display("FAIL mid_rst_report: got %0d bytes expected 9 starting 0a", rx_bytes.size());
        end
    endtask

    task automatic test_random;
        int g0;
        bit ok;
        rx_bytes.delete();
        g0 = gnt_log.size();
        rand_busy = 1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                    else req_data[32*i +: 32] = $urandom;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        req_data[32*i +: 32] = $urandom;
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 15) == 0) tx_block = !tx_block;
        end
        req_valid = '0;
        tx_block = 1'b0;
        wait_idle(500, ok);
        rand_busy = 0;
        n_checks++;
        if (!ok || rx_bytes.size() != 9 * (gnt_log.size() - g0)) begin
            n_errors++;
            $display("FAIL rand_bytes: got %0d expected %0d", rx_bytes.size(), 9 * (gnt_log.size() - g0));
        end
        n_checks++;
        if (gnt_log.size() - g0 < 10) begin
            n_errors++;
            $display("FAIL rand_progress: got %0d reports expected >= 10", gnt_log.size() - g0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_fairness;
        test_single;
        test_flow_block;
        test_flow_busy;
        test_withdraw;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
